data_mem_access_unit: RTL and testbench

Memory-stage access unit sitting between the execute stage and the data memory port. It consumes the MemRead/MemWrite/MemtoReg/RegWrite control bits produced by the main control decoder, issues handshaked word accesses to data memory, and stalls the pipeline until each access completes. It then presents a registered writeback result (load data or ALU result) to the register file.

---
 rtl/data_mem_access_unit_if.sv | 31 +++
 rtl/data_mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_data_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_unit_if.sv
// Data memory port bundle: word request/ack handshake.
// master drives the request side, slave returns data and ack.
interface data_mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Memory-stage access unit: issues word loads/stores, stalls
// execute until ack or timeout, and registers the writeback.
module data_mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  data_mem_access_unit_if.master mem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic          m2r_q;
  logic          rw_q;

  logic mem_op;
  logic aligned;
  logic accept;
  logic to_hit;

  logic              wb_valid_n;
  logic              wb_rw_n;
  logic              wb_err_n;
  logic [DATA_W-1:0] wb_data_n;

  assign mem_op  = ex_valid & (MemRead | MemWrite);
  assign aligned = (alu_result[1:0] == 2'b00);
  assign to_hit  = (cnt == CW'(TIMEOUT - 1));

  // The state flop itself is the request line, so reset drops it at once.
  assign mem.mem_req = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    stall      = 1'b0;
    accept     = 1'b0;
    wb_valid_n = 1'b0;
    wb_rw_n    = 1'b0;
    wb_err_n   = 1'b0;
    wb_data_n  = '0;
    unique case (state)
      IDLE: begin
        if (mem_op && aligned) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_n = REQ;
        end else if (mem_op) begin
          wb_valid_n = 1'b1;
          wb_err_n   = 1'b1;
        end else if (ex_valid) begin
          wb_valid_n = 1'b1;
          wb_rw_n    = RegWrite;
          wb_data_n  = DATA_W'(alu_result);
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          state_n    = IDLE;
          wb_valid_n = 1'b1;
          wb_rw_n    = rw_q;
          if (m2r_q && !mem.mem_we) begin
            wb_data_n = mem.mem_rdata;
          end else begin
            wb_data_n = DATA_W'(mem.mem_addr);
          end
        end else if (to_hit) begin
          state_n    = IDLE;
          wb_valid_n = 1'b1;
          wb_err_n   = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      m2r_q         <= 1'b0;
      rw_q          <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (accept) begin
      cnt           <= '0;
      m2r_q         <= MemtoReg;
      rw_q          <= RegWrite;
      mem.mem_we    <= MemWrite;
      mem.mem_addr  <= alu_result;
      mem.mem_wdata <= store_data;
    end else if (state == REQ && !mem.mem_ack && !to_hit) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_err       <= 1'b0;
      wb_data      <= '0;
    end else begin
      wb_valid     <= wb_valid_n;
      wb_reg_write <= wb_rw_n;
      wb_err       <= wb_err_n;
      wb_data      <= wb_data_n;
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: directed ops, a writeback
// model keyed by cycle, and per-cycle writeback comparison.
module tb_data_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid;
  logic          MemRead;
  logic          MemWrite;
  logic          MemtoReg;
  logic          RegWrite;
  logic [AW-1:0] alu_result;
  logic [DW-1:0] store_data;
  logic          stall;
  logic          wb_valid;
  logic          wb_reg_write;
  logic [DW-1:0] wb_data;
  logic          wb_err;

  data_mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  data_mem_access_unit #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .stall       (stall),
    .mem         (mif.master),
    .wb_valid    (wb_valid),
    .wb_reg_write(wb_reg_write),
    .wb_data     (wb_data),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // Expected writeback per cycle: {reg_write, err, data}.
  logic [DW+1:0] exp_q [int];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [DW+1:0] model(
    input logic rd, input logic wr, input logic m2r, input logic rw,
    input logic [AW-1:0] a, input logic [DW-1:0] rdata, input bit tmo);
    if (!(rd || wr)) return {rw, 1'b0, a};
    if (a[1:0] != 2'b00 || tmo) return {1'b0, 1'b1, {DW{1'b0}}};
    if (rd && !wr && m2r) return {rw, 1'b0, rdata};
    return {rw, 1'b0, a};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.exists(cyc)) begin
        chk1("wb_valid", wb_valid, 1'b1);
        chk1("wb_reg_write", wb_reg_write, exp_q[cyc][DW+1]);
        chk1("wb_err", wb_err, exp_q[cyc][DW]);
        chk("wb_data", wb_data, exp_q[cyc][DW-1:0]);
        exp_q.delete(cyc);
      end else begin
        chk1("wb_quiet", wb_valid, 1'b0);
      end
    end
  end

  // Presents one op; waits<0 means memory never acks.
  task automatic do_op(input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] sd, input int waits,
                       input logic [DW-1:0] rdata);
    bit memop;
    bit tmo;
    bit fin;
    ex_valid   = 1'b1;
    MemRead    = rd;
    MemWrite   = wr;
    MemtoReg   = m2r;
    RegWrite   = rw;
    alu_result = a;
    store_data = sd;
    memop = (rd || wr) && (a[1:0] == 2'b00);
    if (!memop) exp_q[cyc+1] = model(rd, wr, m2r, rw, a, '0, 1'b0);
    @(negedge clk);
    chk1("stall_c0", stall, memop);
    chk1("req_c0", mif.mem_req, 1'b0);
    if (memop) begin
      fin = 1'b0;
      for (int k = 1; k <= TO && !fin; k++) begin
        @(posedge clk);
        #1;
        mif.mem_ack   = (k == waits + 1);
        mif.mem_rdata = mif.mem_ack ? rdata : (32'hBAD0_0000 | k);
        tmo = !mif.mem_ack && (k == TO);
        fin = mif.mem_ack || tmo;
        if (fin) exp_q[cyc+1] = model(rd, wr, m2r, rw, a, rdata, tmo);
        @(negedge clk);
        chk1("mem_req", mif.mem_req, 1'b1);
        chk("mem_addr", mif.mem_addr, a);
        chk1("mem_we", mif.mem_we, wr);
        if (wr) chk("mem_wdata", mif.mem_wdata, sd);
        chk1("stall_req", stall, !fin);
      end
    end
    @(posedge clk);
    #1;
    ex_valid    = 1'b0;
    mif.mem_ack = 1'b0;
  endtask

  initial begin
    ex_valid      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    alu_result    = '0;
    store_data    = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    #2;
    chk1("rst_mem_req", mif.mem_req, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk1("rst_wb_err", wb_err, 1'b0);
    ex_valid   = 1'b1;
    MemRead    = 1'b1;
    alu_result = 32'h40;
    #1;
    chk1("rst_stall_memop", stall, 1'b1);
    ex_valid = 1'b0;
    MemRead  = 1'b0;
    #1;
    chk1("rst_stall_idle", stall, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset asserted while a request is outstanding.
    ex_valid   = 1'b1;
    MemRead    = 1'b1;
    MemtoReg   = 1'b1;
    RegWrite   = 1'b1;
    alu_result = 32'h100;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("mid_req_up", mif.mem_req, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_req_drop", mif.mem_req, 1'b0);
    ex_valid = 1'b0;
    MemRead  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("post_rst_req", mif.mem_req, 1'b0);

    // Load, zero wait states.
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lit_load_data", wb_data, 32'hDEAD_BEEF);
    chk1("lit_load_rw", wb_reg_write, 1'b1);
    @(posedge clk);
    #1;

    // Store with three wait states (MemRead also set).
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h1234_5678, 3, 32'hFFFF_0000);
    @(negedge clk);
    chk1("lit_store_rw", wb_reg_write, 1'b0);
    chk("lit_store_data", wb_data, 32'h80);
    @(posedge clk);
    #1;

    // R-type, load, store back-to-back.
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 0, 32'h0);
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 1, 32'hCAFE_F00D);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h48, 32'hA5A5_5A5A, 0, 32'h0);
    do_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h4C, 32'h0, 2, 32'h1111_2222);

    // Misaligned load, then misaligned store back-to-back.
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 0, 32'h0);
    do_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h81, 32'h55, 0, 32'h0);
    @(negedge clk);
    chk1("lit_mis_err", wb_err, 1'b1);
    chk("lit_mis_data", wb_data, 32'h0);
    chk1("lit_mis_rw", wb_reg_write, 1'b0);
    chk1("lit_mis_req", mif.mem_req, 1'b0);
    @(posedge clk);
    #1;

    // MemRead without ex_valid is not an op.
    MemRead    = 1'b1;
    alu_result = 32'h90;
    @(negedge clk);
    chk1("novalid_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    MemRead = 1'b0;

    // Timeout, then a spurious ack in IDLE.
    do_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, -1, 32'h0);
    @(negedge clk);
    chk1("lit_to_err", wb_err, 1'b1);
    chk1("lit_to_rw", wb_reg_write, 1'b0);
    @(posedge clk);
    #1;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk1("spur_req", mif.mem_req, 1'b0);
    chk1("spur_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    mif.mem_ack = 1'b0;
    @(negedge clk);
    chk1("spur_req2", mif.mem_req, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("exp_drained", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
